// File: rtl/spi_slave_fifo_if.sv
`timescale 1ns/1ps
// System-side word streams of spi_slave_fifo: TX words in, RX words out.
interface spi_slave_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_fifo.sv
`timescale 1ns/1ps
// SPI slave with configurable word width, all CPOL/CPHA modes, back-to-back
// words per frame, and TX/RX FIFOs toward the system clock domain.
module spi_slave_fifo #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cpol,
    input  logic                        cpha,
    input  logic                        cs_bar,
    input  logic                        sclk,
    input  logic                        mosi,
    output logic                        miso,
    spi_slave_fifo_if.slave             bus,
    output logic [$clog2(FIFO_DEPTH):0] tx_level,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        busy,
    output logic                        rx_overflow,
    output logic                        tx_underrun,
    input  logic                        clear_flags
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_s, cs_s, mosi_s, sclk_prev, cs_prev;
    logic cs_fall, cs_rise, lead_edge, trail_edge, sample_edge, shift_edge;

    logic              cpol_l, cpha_l;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic              tx_pending, seen_sample, rx_push_req;
    logic              frame_start, frame_end, tx_load;

    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
    logic [AW:0]       tx_cnt, rx_cnt;
    logic              tx_empty, tx_push, tx_pop;
    logic              rx_full, rx_push, rx_pop, rx_drop;
    logic [DATA_W-1:0] tx_head;

    // Pin synchronisers plus previous-value registers for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_bar};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign cs_fall     = cs_prev && !cs_s;
    assign cs_rise     = !cs_prev && cs_s;
    assign lead_edge   = (sclk_prev == cpol_l) && (sclk_s != cpol_l);
    assign trail_edge  = (sclk_prev != cpol_l) && (sclk_s == cpol_l);
    assign sample_edge = cpha_l ? trail_edge : lead_edge;
    assign shift_edge  = cpha_l ? lead_edge : trail_edge;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state, frame boundaries and TX FIFO load requests.
    always_comb begin
        state_nx    = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        tx_load     = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nx    = ACTIVE;
                    frame_start = 1'b1;
                    tx_load     = !cpha && !tx_pending;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_nx  = IDLE;
                    frame_end = 1'b1;
                end else if (shift_edge && bit_cnt == '0) begin
                    // In mode cpha=0 the first word was loaded at CS fall.
                    tx_load = cpha_l || seen_sample;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shift registers, bit counter and preload bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            bit_cnt     <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            tx_pending  <= 1'b0;
            seen_sample <= 1'b0;
            rx_push_req <= 1'b0;
        end else begin
            rx_push_req <= 1'b0;
            if (frame_start) begin
                cpol_l      <= cpol;
                cpha_l      <= cpha;
                bit_cnt     <= '0;
                seen_sample <= 1'b0;
                if (!cpha) begin
                    if (tx_pending) tx_pending <= 1'b0;
                    else            tx_sh      <= tx_head;
                end
            end else if (frame_end) begin
                bit_cnt <= '0;
                // A word preloaded at a word boundary survives into the next frame.
                if (!(bit_cnt == '0 && tx_pending)) begin
                    tx_sh      <= '0;
                    tx_pending <= 1'b0;
                end
            end else if (state == ACTIVE) begin
                if (shift_edge) begin
                    if (bit_cnt == '0) begin
                        if (tx_load) begin
                            tx_sh <= tx_head;
                            if (!cpha_l) tx_pending <= 1'b1;
                        end
                    end else begin
                        tx_sh      <= {tx_sh[DATA_W-2:0], 1'b0};
                        tx_pending <= 1'b0;
                    end
                end
                if (sample_edge) begin
                    rx_sh       <= {rx_sh[DATA_W-2:0], mosi_s};
                    seen_sample <= 1'b1;
                    if (bit_cnt == '0) tx_pending <= 1'b0;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt     <= '0;
                        rx_push_req <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Registered MISO; held low outside a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) miso <= 1'b0;
        else        miso <= (state == ACTIVE) ? tx_sh[DATA_W-1] : 1'b0;
    end

    assign busy = (state == ACTIVE);

    assign tx_empty     = (tx_cnt == '0);
    assign bus.tx_ready = (tx_cnt != FULL);
    assign tx_push      = bus.tx_valid && bus.tx_ready;
    assign tx_pop       = tx_load && !tx_empty;
    assign tx_head      = tx_empty ? '0 : tx_mem[tx_rp];
    assign tx_level     = tx_cnt;

    assign rx_full      = (rx_cnt == FULL);
    assign bus.rx_valid = (rx_cnt != '0);
    assign bus.rx_data  = rx_mem[rx_rp];
    assign rx_pop       = bus.rx_valid && bus.rx_ready;
    assign rx_push      = rx_push_req && (!rx_full || rx_pop);
    assign rx_drop      = rx_push_req && rx_full && !rx_pop;
    assign rx_level     = rx_cnt;

    // FIFO storage writes.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.tx_data;
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
    end

    // FIFO pointers and occupancy counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_overflow <= rx_drop || (rx_overflow && !clear_flags);
            tx_underrun <= (tx_load && tx_empty) || (tx_underrun && !clear_flags);
        end
    end
endmodule

// File: tb/tb_spi_slave_fifo.sv
`timescale 1ns/1ps
// Directed bench for spi_slave_fifo acting as the SPI master and system side.
module tb_spi_slave_fifo;
    localparam int HALF = 8;  // clk cycles per SCLK half period

    logic       clk = 1'b0;
    logic       reset, cpol, cpha, cs_bar, sclk, mosi, miso, clear_flags;
    logic [2:0] tx_level, rx_level;
    logic       busy, rx_overflow, tx_underrun;

    logic [7:0] mosi_words [5];
    logic [7:0] miso_words [5];
    time        t_samp, t_valid;
    int         n_checks = 0;
    int         n_fail   = 0;

    spi_slave_fifo_if #(.DATA_W(8)) bus ();

    spi_slave_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .cs_bar(cs_bar),
        .sclk(sclk), .mosi(mosi), .miso(miso), .bus(bus),
        .tx_level(tx_level), .rx_level(rx_level), .busy(busy),
        .rx_overflow(rx_overflow), .tx_underrun(tx_underrun),
        .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    always @(posedge bus.rx_valid) t_valid = $time;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] w);
        @(negedge clk);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check(tag, {31'd0, bus.rx_valid} << 8 | bus.rx_data, {23'd0, 1'b1, exp});
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        @(negedge clk);
    endtask

    task automatic xfer_bit(input logic m, output logic s);
        if (!cpha) begin
            mosi = m;
            half();
            s      = miso;
            sclk   = ~cpol;
            t_samp = $time;
            half();
            sclk   = cpol;
        end else begin
            sclk = ~cpol;
            mosi = m;
            half();
            s      = miso;
            sclk   = cpol;
            t_samp = $time;
            half();
        end
    endtask

    task automatic run_frame(input int n_words, input int stop_bits);
        int   sent = 0;
        logic b;
        cs_bar = 1'b0;
        half();
        for (int w = 0; w < n_words; w++) begin
            for (int i = 7; i >= 0; i--) begin
                if (stop_bits == 0 || sent < stop_bits) begin
                    xfer_bit(mosi_words[w][i], b);
                    miso_words[w][i] = b;
                    sent++;
                end
            end
        end
        half();
        cs_bar = 1'b1;
        half();
        half();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic b;
        reset = 1'b0; cs_bar = 1'b1; sclk = 1'b0; mosi = 1'b0;
        cpol = 1'b0; cpha = 1'b0; clear_flags = 1'b0;
        bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_rx_overflow", rx_overflow, 0);
        check("rst_tx_underrun", tx_underrun, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0, single word
        push_tx(8'hA5);
        check("m0_tx_level_pre", tx_level, 1);
        mosi_words[0] = 8'h3C;
        run_frame(1, 0);
        check("m0_miso", miso_words[0], 8'hA5);
        check("m0_tx_level_post", tx_level, 0);
        check("m0_rx_level", rx_level, 1);
        check("m0_latency", int'((t_valid - t_samp + 5) / 10), 4);
        check("m0_underrun_end_load", tx_underrun, 1);
        pop_check("m0_rx", 8'h3C);
        pulse_clear();
        check("m0_clear_underrun", tx_underrun, 0);

        // Mode 3, two back-to-back words
        cpol = 1'b1; cpha = 1'b1; sclk = 1'b1;
        half();
        push_tx(8'h81);
        push_tx(8'h7E);
        mosi_words[0] = 8'h11;
        mosi_words[1] = 8'h22;
        run_frame(2, 0);
        check("m3_miso0", miso_words[0], 8'h81);
        check("m3_miso1", miso_words[1], 8'h7E);
        check("m3_rx_level", rx_level, 2);
        check("m3_tx_level", tx_level, 0);
        check("m3_underrun", tx_underrun, 0);
        pop_check("m3_rx0", 8'h11);
        pop_check("m3_rx1", 8'h22);
        cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
        half();

        // Mode 0 preload carried across frames
        push_tx(8'h55);
        push_tx(8'h66);
        mosi_words[0] = 8'h5A;
        run_frame(1, 0);
        check("pre_f1_miso", miso_words[0], 8'h55);
        check("pre_f1_tx_level", tx_level, 0);
        check("pre_f1_underrun", tx_underrun, 0);
        pop_check("pre_f1_rx", 8'h5A);
        push_tx(8'h77);
        check("pre_tx_level", tx_level, 1);
        mosi_words[0] = 8'hC3;
        run_frame(1, 0);
        check("pre_f2_miso", miso_words[0], 8'h66);
        check("pre_f2_tx_level", tx_level, 0);
        check("pre_f2_underrun", tx_underrun, 0);
        pop_check("pre_f2_rx", 8'hC3);
        mosi_words[0] = 8'h0F;
        run_frame(1, 0);
        check("pre_f3_miso", miso_words[0], 8'h77);
        check("pre_f3_underrun", tx_underrun, 1);
        pop_check("pre_f3_rx", 8'h0F);
        pulse_clear();

        // Overflow and underrun: empty TX, five words, no RX pops
        for (int i = 0; i < 5; i++) mosi_words[i] = 8'(i + 1);
        run_frame(5, 0);
        for (int i = 0; i < 5; i++) check($sformatf("ovf_miso%0d", i), miso_words[i], 0);
        check("ovf_underrun", tx_underrun, 1);
        check("ovf_rx_level", rx_level, 4);
        check("ovf_overflow", rx_overflow, 1);
        for (int i = 0; i < 4; i++) pop_check($sformatf("ovf_rx%0d", i), 8'(i + 1));
        check("ovf_rx_level_drained", rx_level, 0);
        pulse_clear();
        check("ovf_clear_overflow", rx_overflow, 0);
        check("ovf_clear_underrun", tx_underrun, 0);

        // Abort after 5 bits, then a full frame
        mosi_words[0] = 8'hFF;
        run_frame(1, 5);
        check("abort_rx_level", rx_level, 0);
        check("abort_busy", busy, 0);
        push_tx(8'h3A);
        mosi_words[0] = 8'h4B;
        run_frame(1, 0);
        check("abort_next_miso", miso_words[0], 8'h3A);
        check("abort_next_rx_level", rx_level, 1);
        check("abort_next_rx_data", bus.rx_data, 8'h4B);

        // Asynchronous reset in the middle of a frame
        push_tx(8'hC3);
        push_tx(8'hD4);
        check("mid_pre_tx_level", tx_level, 2);
        check("mid_pre_underrun", tx_underrun, 1);
        cs_bar = 1'b0;
        half();
        for (int i = 0; i < 3; i++) xfer_bit(1'b1, b);
        check("mid_pre_busy", busy, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_miso", miso, 0);
        check("mid_busy", busy, 0);
        check("mid_tx_ready", bus.tx_ready, 1);
        check("mid_rx_valid", bus.rx_valid, 0);
        check("mid_tx_level", tx_level, 0);
        check("mid_rx_level", rx_level, 0);
        check("mid_overflow", rx_overflow, 0);
        check("mid_underrun", tx_underrun, 0);
        cs_bar = 1'b1; sclk = 1'b0; mosi = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("post_busy", busy, 0);
        check("post_tx_level", tx_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
